// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and parity helper for the 4-lane TDM demultiplexer.
package tdm_pkg;

    localparam int LANES = 4;
    localparam int SLOTW = 2;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RUN  = 2'd1,
        PAR  = 2'd2
    } state_t;

    // Returns the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/tdm_demux4_demux1_4.sv
// 1:4 select decoder producing the one-hot lane write enable for the shadow register.
module demux1_4
    import tdm_pkg::*;
(
    input  logic [SLOTW-1:0] sel,
    input  logic             en,
    output logic [LANES-1:0] we
);

    always_comb begin
        we = '0;
        if (en) we[sel] = 1'b1;
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-lane TDM demultiplexer: rebuilds one WORDW-bit word per lane from a rotating serial stream.
// Optional trailing even-parity bit per frame when TDM_DEMUX_PARITY_EN is defined.
//
// state | meaning
// HUNT  | waiting for the first frame_sync after reset
// RUN   | assembling a frame into the shadow register
// PAR   | frame complete, next valid bit is its parity (parity build only)
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WORDW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   din,
    input  logic                   din_valid,
    input  logic                   frame_sync,
    output logic [LANES*WORDW-1:0] dout,
    output logic                   frame_valid,
    output logic                   sync_err,
    output logic                   parity_err
);

    localparam int FW = LANES * WORDW;
    localparam int BW = $clog2(WORDW);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORDW - 1);

    state_t           state;
    logic [SLOTW-1:0] slot;
    logic [BW-1:0]    bitc;
    logic [FW-1:0]    shadow;
    logic [FW-1:0]    shadow_wr;
    logic [LANES-1:0] lane_we;
    logic             aligned;
    logic             last_bit;

    assign aligned  = (slot == '0) && (bitc == '0);
    assign last_bit = (slot == SLOTW'(LANES - 1)) && (bitc == BIT_LAST);

    demux1_4 u_demux (
        .sel (slot),
        .en  (din_valid && (state == RUN)),
        .we  (lane_we)
    );

    always_comb begin
        shadow_wr = shadow;
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l]) shadow_wr[l*WORDW + int'(bitc)] = din;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    logic par_err_q;
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= '0;
            bitc        <= '0;
            shadow      <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            shadow <= {{(FW-1){1'b0}}, din};
                            slot   <= SLOTW'(1);
                            bitc   <= '0;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        if (frame_sync && !aligned) begin
                            // Misplaced sync: drop the partial frame and realign on this bit.
                            sync_err <= 1'b1;
                            shadow   <= {{(FW-1){1'b0}}, din};
                            slot     <= SLOTW'(1);
                            bitc     <= '0;
                        end else begin
                            shadow <= shadow_wr;
                            if (last_bit) begin
                                slot <= '0;
                                bitc <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                                state <= PAR;
`else
                                dout        <= shadow_wr;
                                frame_valid <= 1'b1;
`endif
                            end else begin
                                slot <= slot + SLOTW'(1);
                                if (slot == SLOTW'(LANES - 1)) bitc <= bitc + BW'(1);
                            end
                        end
                    end
`ifdef TDM_DEMUX_PARITY_EN
                    PAR: begin
                        state <= RUN;
                        if (frame_sync) begin
                            sync_err <= 1'b1;
                            shadow   <= {{(FW-1){1'b0}}, din};
                            slot     <= SLOTW'(1);
                            bitc     <= '0;
                        end else begin
                            slot <= '0;
                            bitc <= '0;
                            if (din == even_parity(64'(shadow))) begin
                                dout        <= shadow;
                                frame_valid <= 1'b1;
                            end else begin
                                par_err_q <= 1'b1;
                            end
                        end
                    end
`endif
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4 (WORDW=4); parity scenarios run when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux4;

    localparam logic [2:0] K_FV = 3'b001;
    localparam logic [2:0] K_SE = 3'b010;
    localparam logic [2:0] K_PE = 3'b100;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [15:0] dout;
    logic        frame_valid;
    logic        sync_err;
    logic        parity_err;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        expq[$];
    int          fv_cyc[$];
    logic [15:0] exp_dout = '0;

    tdm_demux4 #(.WORDW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (frame_valid || sync_err || parity_err) begin
            exp_t e;
            logic [2:0] got;
            got = {parity_err, sync_err, frame_valid};
            if (frame_valid) fv_cyc.push_back(cyc);
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got kind=%b dout=%h, required no event", got, dout);
            end else begin
                e = expq.pop_front();
                if (got != e.kind) begin
                    bad++;
                    $display("FAIL event_kind: got %b, required %b", got, e.kind);
                end
                total++;
                if (dout != e.data) begin
                    bad++;
                    $display("FAIL event_dout: got %h, required %h", dout, e.data);
                end
            end
        end
    end

    task automatic drive(input logic d, input logic v, input logic s);
        @(posedge clk);
        #1;
        din        = d;
        din_valid  = v;
        frame_sync = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Lane s bit b is w[s*4+b]; bits go LSB first with lanes rotating.
    task automatic send_frame(input logic [15:0] w, input int gap, input bit bad_par);
        exp_t e;
`ifdef TDM_DEMUX_PARITY_EN
        if (bad_par) begin
            e.kind = K_PE; e.data = exp_dout;
        end else begin
            e.kind = K_FV; e.data = w; exp_dout = w;
        end
`else
        e.kind = K_FV; e.data = w; exp_dout = w;
`endif
        expq.push_back(e);
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 4; s++) begin
                drive(w[s*4+b], 1'b1, (b == 0) && (s == 0));
                if (gap > 0) idle(gap);
            end
        end
`ifdef TDM_DEMUX_PARITY_EN
        drive((^w) ^ bad_par, 1'b1, 1'b0);
`endif
    endtask

    task automatic check_zero(input string nm, input logic [15:0] got);
        total++;
        if (got != '0) begin
            bad++;
            $display("FAIL %s: got %h, required 0", nm, got);
        end
    endtask

    task automatic check_outputs_reset();
        check_zero("rst_dout", dout);
        check_zero("rst_frame_valid", {15'b0, frame_valid});
        check_zero("rst_sync_err", {15'b0, sync_err});
        check_zero("rst_parity_err", {15'b0, parity_err});
    endtask

    initial begin
        logic [15:0] pat;
        exp_t e;
        int n0;
        int span;

        // Reset from time zero, then unsynced traffic must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check_outputs_reset();
        rst_n = 1'b1;
        pat = 16'hBEEF;
        for (int i = 0; i < 20; i++) drive(pat[i % 16], 1'b1, 1'b0);
        idle(3);

        // Single frame, then the same frame with 3-cycle gaps.
        send_frame(16'h4321, 0, 1'b0);
        idle(3);
        send_frame(16'h4321, 3, 1'b0);
        idle(3);

        // Sync on bit 7 of a frame: error, dout held, realign on that bit.
        e.kind = K_SE; e.data = exp_dout;
        expq.push_back(e);
        pat = 16'h1234;
        for (int i = 0; i < 7; i++) drive(pat[(i % 4)*4 + i/4], 1'b1, i == 0);
        send_frame(16'hA5C3, 0, 1'b0);
        idle(3);

        // Back-to-back frames with continuous valid.
        n0 = fv_cyc.size();
        send_frame(16'h4321, 0, 1'b0);
        send_frame(16'hA5C3, 0, 1'b0);
        idle(3);
`ifdef TDM_DEMUX_PARITY_EN
        span = 17;
`else
        span = 16;
`endif
        total++;
        if (fv_cyc.size() < n0 + 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d pulses, required 2", fv_cyc.size() - n0);
        end else if (fv_cyc[n0+1] - fv_cyc[n0] != span) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d, required %0d", fv_cyc[n0+1] - fv_cyc[n0], span);
        end

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(16'h4321, 0, 1'b0);
        send_frame(16'hA5C3, 0, 1'b0);
        send_frame(16'h4321, 0, 1'b1);
        idle(3);
`endif

        // Reset mid-frame clears everything; HUNT ignores unsynced bits afterwards.
        pat = 16'h5A5A;
        for (int i = 0; i < 8; i++) drive(pat[i], 1'b1, i == 0);
        rst_n = 1'b0;
        #2;
        check_outputs_reset();
        exp_dout = '0;
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(pat[i % 16], 1'b1, 1'b0);
        idle(2);
        send_frame(16'h0F96, 0, 1'b0);
        idle(5);

        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d pending, required 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-lane time-division demultiplexer. It receives a single-bit serial stream in which consecutive valid bits rotate through slots 0..3, and reassembles one WORDW-bit word per lane. The upstream transmitter is the rotating-select 4:1 multiplexer serializer. This block sits at the receive end of that link and hands complete, aligned 4-lane frames to downstream logic.

## Interface
- WORDW, default 4: bits per lane word; legal range 2..16.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only when this is high.
- frame_sync  input  1  qualified by din_valid; marks the current bit as lane 0, bit 0 of a new frame.
- dout  output  4*WORDW  lane i word at dout[i*WORDW +: WORDW]; registered.
- frame_valid  output  1  one-cycle pulse; a new frame is on dout.
- sync_err  output  1  one-cycle pulse; the frame_sync position was wrong or the frame was incomplete.
- parity_err  output  1  one-cycle pulse; present only with TDM_DEMUX_PARITY_EN and tied 0 otherwise.

## Operation
- States:
  - HUNT: after reset; ignore din until a valid frame_sync is seen.
  - RUN: assembling a frame.
  - PAR: parity bit expected; exists only with TDM_DEMUX_PARITY_EN.
- HUNT -> RUN on din_valid && frame_sync. That bit is stored as lane 0 bit 0, then slot=1 and bit=0.
- In RUN, each valid bit is written to shadow[slot][bit], LSB first.
- slot increments modulo 4. When slot wraps 3->0, bit increments.
- A valid bit at slot=3, bit=WORDW-1 completes the frame:
  - without parity: shadow (including this bit) is copied to dout, frame_valid pulses, counters return to 0, state stays RUN;
  - with parity: go to PAR.
- frame_sync at slot=0, bit=0 in RUN is the expected alignment. It is accepted silently.
- frame_sync at any other position in RUN:
  - sync_err pulses;
  - the partial frame is discarded and dout is unchanged;
  - the current bit is taken as lane 0 bit 0 of a new frame.
- din_valid low: no state change. Gaps of any length are legal mid-frame.
- frame_sync with din_valid low is ignored.
- Shadow register has 4*WORDW bits. dout is only ever loaded from a complete frame and holds its value between frames.
- Slot decode: a one-hot lane write enable is derived from slot, i.e. a 1:4 decoder.

## Timing
- Reset values: dout=0, frame_valid=0, sync_err=0, parity_err=0, state=HUNT, slot=0, bit=0, shadow=0.
- Latency: dout and frame_valid are valid in the cycle after the edge that samples the last frame bit (or the parity bit). This is a 1-cycle registered latency.
- Back-to-back frames: a valid bit can be accepted every cycle. A frame_sync on the cycle right after completion is the legal aligned case.
- Reset asserted mid-frame: all state clears immediately, including any pending pulse. The partial frame is lost and no error is flagged.
- Simultaneous completion and frame_sync on the same bit: only possible when WORDW*4==1, which cannot occur. No rule is needed.

## Configuration
- TDM_DEMUX_PARITY_EN defined:
  - each frame is followed by one extra valid bit carrying even parity over all 4*WORDW data bits;
  - in PAR, the next valid bit is checked;
  - on match: dout is loaded and frame_valid pulses;
  - on mismatch: parity_err pulses and dout is unchanged;
  - in both cases, go to RUN with counters at 0;
  - frame_sync on the parity bit pulses sync_err, discards the frame, and restarts as in RUN.
- Undefined: there is no PAR state and parity_err is tied 0.

## Structure
- Package tdm_pkg holds:
  - LANES=4 and SLOTW=2;
  - state encoding constants HUNT/RUN/PAR;
  - the even-parity helper function.
- One sub-module, demux1_4: takes a 2-bit select and an enable, and produces a 4-bit one-hot lane write enable. It is combinational and instantiated once.
- Top level holds the FSM, the slot/bit counters, the shadow and dout registers, and the pulse flops.

## Test plan
All scenarios use WORDW=4.
- Reset: drive rst_n=0 mid-stream.
  - -> all outputs 0 and state HUNT.
  - After release, bits without frame_sync -> no frame_valid.
- Single frame: frame_sync on first bit, then 16 valid bits encoding lanes 0x1,0x2,0x3,0x4 (LSB first, rotating lanes).
  - -> one cycle after the 16th bit, dout=0x4321 and frame_valid pulses once.
- Gaps: same frame with din_valid low for 3 cycles between every bit.
  - -> identical dout=0x4321, frame_valid asserted exactly once.
- Misaligned sync: frame_sync asserted on bit 7 of a frame.
  - -> sync_err pulses and dout keeps its prior value.
  - The next 16 bits (from that sync) yield a correct frame.
- Back-to-back frames: two frames 0x4321 then 0xA5C3 with continuous valid.
  - -> frame_valid pulses 16 cycles apart, and dout changes in the order listed.
- With TDM_DEMUX_PARITY_EN:
  - frame 0x4321 (popcount 5) plus parity bit 1 -> frame_valid pulses;
  - the same frame with parity bit 0 -> parity_err pulses, dout unchanged.
